// File: rtl/chess_clock_pkg.sv
// Shared constants, FSM state type and small helpers for the chess clock display.
package chess_clock_pkg;

  localparam logic [15:0] MAX_DISPLAY_SECONDS = 16'd5999;

  // Segment codes {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_DIV,
    ST_BCD,
    ST_COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [15:0] saturate(input logic [15:0] t);
    return (t > MAX_DISPLAY_SECONDS) ? MAX_DISPLAY_SECONDS : t;
  endfunction

endpackage

// File: rtl/time_to_mmss.sv
// Seconds to MM:SS BCD: 16-cycle restoring divide by 60, then 7-cycle double-dabble.
module time_to_mmss
  import chess_clock_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] seconds,
  output logic        div_done,
  output logic        done,
  output logic [7:0]  mm_bcd,
  output logic [7:0]  ss_bcd
);

  // Handshake: start is a one-cycle pulse that loads seconds (and aborts any run);
  // div_done is high on the last divide cycle; done is high on the last BCD cycle,
  // and mm_bcd/ss_bcd are valid only in that cycle.

  logic        div_run;
  logic        bcd_run;
  logic [3:0]  step;
  logic [15:0] qd;
  logic [5:0]  rem;
  logic [6:0]  m_bin;
  logic [6:0]  s_bin;
  logic [7:0]  m_acc;
  logic [7:0]  s_acc;

  logic [6:0]  trial;
  logic        fits;
  logic [5:0]  rem_next;
  logic [15:0] qd_next;

  function automatic logic [7:0] dabble(input logic [7:0] acc, input logic b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    hi = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
    return 8'({hi, lo, b});
  endfunction

  always_comb begin
    trial    = {rem, qd[15]};
    fits     = (trial >= 7'd60);
    rem_next = fits ? 6'(trial - 7'd60) : trial[5:0];
    qd_next  = {qd[14:0], fits};
    mm_bcd   = dabble(m_acc, m_bin[6]);
    ss_bcd   = dabble(s_acc, s_bin[6]);
    div_done = div_run && (step == 4'd15);
    done     = bcd_run && (step == 4'd6);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_run <= 1'b0;
      bcd_run <= 1'b0;
      step    <= '0;
      qd      <= '0;
      rem     <= '0;
      m_bin   <= '0;
      s_bin   <= '0;
      m_acc   <= '0;
      s_acc   <= '0;
    end else if (start) begin
      div_run <= 1'b1;
      bcd_run <= 1'b0;
      step    <= '0;
      qd      <= seconds;
      rem     <= '0;
    end else if (div_run) begin
      qd   <= qd_next;
      rem  <= rem_next;
      step <= step + 4'd1;
      if (step == 4'd15) begin
        // Quotient fits in 7 bits because the input is saturated to 5999
        div_run <= 1'b0;
        bcd_run <= 1'b1;
        step    <= '0;
        m_bin   <= qd_next[6:0];
        s_bin   <= {1'b0, rem_next};
        m_acc   <= '0;
        s_acc   <= '0;
      end
    end else if (bcd_run) begin
      m_acc <= mm_bcd;
      s_acc <= ss_bcd;
      m_bin <= {m_bin[5:0], 1'b0};
      s_bin <= {s_bin[5:0], 1'b0};
      step  <= step + 4'd1;
      if (step == 4'd6) bcd_run <= 1'b0;
    end
  end

endmodule

// File: rtl/chess_clock_display.sv
// Snapshots both players' times each frame, converts to MM:SS and drives an
// 8-digit multiplexed active-low 7-segment display with blinking colons.
module chess_clock_display
  import chess_clock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] player1_time,
  input  logic [15:0] player2_time,
  input  logic        player1_flag,
  input  logic        player2_flag,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        valid,
  output conv_state_e state_dbg
);

  conv_state_e state;
  conv_state_e state_next;

  logic        first_pending;
  logic        player;
  logic [15:0] p2_hold;
  logic [15:0] p1_bcd;
  logic [15:0] p2_bcd;
  logic [31:0] digit_bits;

  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [7:0]  frame_cnt;
  logic        blink_phase;
  logic        scan_wrap;
  logic        frame_end;

  logic        conv_start;
  logic [15:0] conv_value;
  logic        conv_div_done;
  logic        conv_done;
  logic [7:0]  conv_mm;
  logic [7:0]  conv_ss;

  logic [3:0]  cur_digit;
  logic        colon_lit;

  time_to_mmss u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .seconds  (conv_value),
    .div_done (conv_div_done),
    .done     (conv_done),
    .mm_bcd   (conv_mm),
    .ss_bcd   (conv_ss)
  );

  assign scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));
  assign frame_end = scan_wrap && (digit_idx == 3'd7);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    conv_value = p2_hold;
    case (state)
      ST_IDLE:   if (first_pending || frame_end) state_next = ST_SAMPLE;
      ST_SAMPLE: begin
        conv_start = 1'b1;
        conv_value = saturate(player1_time);
        state_next = ST_DIV;
      end
      ST_DIV:    if (conv_div_done) state_next = ST_BCD;
      ST_BCD: begin
        if (conv_done) begin
          if (!player) begin
            conv_start = 1'b1;
            state_next = ST_DIV;
          end else begin
            state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      first_pending <= 1'b1;
      player        <= 1'b0;
      p2_hold       <= '0;
      p1_bcd        <= '0;
      p2_bcd        <= '0;
      digit_bits    <= '0;
      valid         <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) first_pending <= 1'b0;
      if (state == ST_SAMPLE) begin
        p2_hold <= saturate(player2_time);
        player  <= 1'b0;
      end
      if (state == ST_BCD && conv_done) begin
        if (!player) begin
          p1_bcd <= {conv_mm, conv_ss};
          player <= 1'b1;
        end else begin
          p2_bcd <= {conv_mm, conv_ss};
        end
      end
      if (state == ST_COMMIT) begin
        digit_bits <= {p1_bcd, p2_bcd};
        valid      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
      if (frame_end) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Flags are used live so a change of move shows without waiting for a frame
  always_comb begin
    cur_digit = digit_bits[{digit_idx, 2'b00} +: 4];
    colon_lit = valid &&
                (((digit_idx == 3'd6) && (!player1_flag || blink_phase)) ||
                 ((digit_idx == 3'd2) && (!player2_flag || blink_phase)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << digit_idx);
      seg <= valid ? seg_encode(cur_digit) : SEG_BLANK;
      dp  <= ~colon_lit;
    end
  end

endmodule
